// File: rtl/irq_dispatcher.sv
// Interrupt dispatcher: picks a pending isr bit, offers it to the CPU with a valid/ack
// handshake, clears it on ack and tracks it until EOI. `IRQ_DISPATCH_RR_EN selects round-robin.
module irq_dispatcher #(
  parameter int NUM_OF_IRQS = 8,
  parameter int IDX_W       = (NUM_OF_IRQS > 1) ? $clog2(NUM_OF_IRQS) : 1,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_OF_IRQS-1:0] isr,
  output logic [NUM_OF_IRQS-1:0] isr_clear,
  input  logic                   dispatch_en,
  output logic                   irq_valid,
  output logic [IDX_W-1:0]       irq_vec,
  input  logic                   cpu_ack,
  input  logic                   cpu_eoi,
  output logic                   in_service,
  output logic                   timeout_err,
  input  logic                   err_clear
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  logic [1:0]             state_q, state_d;
  logic [IDX_W-1:0]       irq_vec_q, irq_vec_d;
  logic                   irq_valid_q, irq_valid_d;
  logic                   in_service_q, in_service_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [NUM_OF_IRQS-1:0] isr_clear_q, isr_clear_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       sel;
  logic                   to_set;

`ifdef IRQ_DISPATCH_RR_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // Rotating search: first pending bit at or after rr_ptr, wrapping modulo NUM_OF_IRQS.
  always_comb begin : rr_sel
    logic [IDX_W:0] j;
    logic           found;
    sel   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < NUM_OF_IRQS; i++) begin
      j = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (j >= (IDX_W+1)'(NUM_OF_IRQS)) j = j - (IDX_W+1)'(NUM_OF_IRQS);
      if (!found && isr[j[IDX_W-1:0]]) begin
        found = 1'b1;
        sel   = j[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == S_REQ && cpu_ack)
      rr_ptr_d = (irq_vec_q == IDX_W'(NUM_OF_IRQS - 1)) ? '0 : irq_vec_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  // Fixed priority: scanning downward leaves the lowest set index in sel.
  always_comb begin
    sel = '0;
    for (int i = NUM_OF_IRQS - 1; i >= 0; i--)
      if (isr[i]) sel = IDX_W'(i);
  end
`endif

  always_comb begin
    state_d       = state_q;
    irq_vec_d     = irq_vec_q;
    irq_valid_d   = irq_valid_q;
    in_service_d  = in_service_q;
    isr_clear_d   = '0;
    cnt_d         = cnt_q;
    to_set        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dispatch_en && (|isr)) begin
          state_d     = S_REQ;
          irq_vec_d   = sel;
          irq_valid_d = 1'b1;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        // ack beats withdraw beats timeout when they coincide
        if (cpu_ack) begin
          state_d      = S_SERVICE;
          irq_valid_d  = 1'b0;
          in_service_d = 1'b1;
          isr_clear_d  = NUM_OF_IRQS'(1) << irq_vec_q;
          cnt_d        = '0;
        end else if (!isr[irq_vec_q]) begin
          state_d     = S_IDLE;
          irq_valid_d = 1'b0;
          cnt_d       = '0;
        end else if ((ACK_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d     = S_IDLE;
          irq_valid_d = 1'b0;
          cnt_d       = '0;
          to_set      = 1'b1;
        end
      end
      S_SERVICE: begin
        if (cpu_eoi) begin
          state_d      = S_IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d      = S_IDLE;
        irq_valid_d  = 1'b0;
        in_service_d = 1'b0;
        cnt_d        = '0;
      end
    endcase
    if (to_set)         timeout_err_d = 1'b1;
    else if (err_clear) timeout_err_d = 1'b0;
    else                timeout_err_d = timeout_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      irq_vec_q     <= '0;
      irq_valid_q   <= 1'b0;
      in_service_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      isr_clear_q   <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      irq_vec_q     <= irq_vec_d;
      irq_valid_q   <= irq_valid_d;
      in_service_q  <= in_service_d;
      timeout_err_q <= timeout_err_d;
      isr_clear_q   <= isr_clear_d;
      cnt_q         <= cnt_d;
    end
  end

  assign isr_clear   = isr_clear_q;
  assign irq_valid   = irq_valid_q;
  assign irq_vec     = irq_vec_q;
  assign in_service  = in_service_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_irq_dispatcher.sv
// Directed bench for irq_dispatcher (ACK_TIMEOUT=4); expectations follow IRQ_DISPATCH_RR_EN.
module tb_irq_dispatcher;
  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  isr;
  logic [N-1:0]  isr_clear;
  logic          dispatch_en;
  logic          irq_valid;
  logic [IW-1:0] irq_vec;
  logic          cpu_ack;
  logic          cpu_eoi;
  logic          in_service;
  logic          timeout_err;
  logic          err_clear;

  int n_chk  = 0;
  int n_fail = 0;

  irq_dispatcher #(.NUM_OF_IRQS(N), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .isr(isr), .isr_clear(isr_clear),
    .dispatch_en(dispatch_en), .irq_valid(irq_valid), .irq_vec(irq_vec),
    .cpu_ack(cpu_ack), .cpu_eoi(cpu_eoi), .in_service(in_service),
    .timeout_err(timeout_err), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

`ifdef IRQ_DISPATCH_RR_EN
  localparam logic [IW-1:0] EXP_FF_VEC = 3'd1;
  localparam logic [IW-1:0] RR_SEQ [4] = '{3'd0, 3'd1, 3'd7, 3'd0};
`else
  localparam logic [IW-1:0] EXP_FF_VEC = 3'd0;
  localparam logic [IW-1:0] RR_SEQ [4] = '{3'd0, 3'd0, 3'd0, 3'd0};
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [IW-1:0] vec,
                         input logic [N-1:0] clr, input logic svc, input logic err);
    chk({tag, ".valid"}, 32'(irq_valid), 32'(v));
    chk({tag, ".vec"},   32'(irq_vec),   32'(vec));
    chk({tag, ".clear"}, 32'(isr_clear), 32'(clr));
    chk({tag, ".svc"},   32'(in_service), 32'(svc));
    chk({tag, ".err"},   32'(timeout_err), 32'(err));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; isr = '0; dispatch_en = 1'b0;
    cpu_ack = 1'b0; cpu_eoi = 1'b0; err_clear = 1'b0;
    #12;
    chk_all("reset", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    tick(); tick();
    rst_n = 1'b1;

    // fixed-priority offer, ack, clear pulse, EOI, then next vector after IDLE gap
    isr = 8'b0010_0100; dispatch_en = 1'b1;
    tick(); chk_all("offer2", 1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
    cpu_ack = 1'b1;
    tick(); chk_all("ack2", 1'b0, 3'd2, 8'h04, 1'b1, 1'b0);
    cpu_ack = 1'b0; isr = 8'b0010_0000;
    tick(); chk_all("svc2", 1'b0, 3'd2, 8'h00, 1'b1, 1'b0);
    cpu_eoi = 1'b1;
    tick(); chk_all("eoi2", 1'b0, 3'd2, 8'h00, 1'b0, 1'b0);
    cpu_eoi = 1'b0;
    tick(); chk_all("offer5", 1'b1, 3'd5, 8'h00, 1'b0, 1'b0);

    // withdraw while offered
    isr = 8'h00;
    tick(); chk_all("wd5", 1'b0, 3'd5, 8'h00, 1'b0, 1'b0);
    isr = 8'h08;
    tick(); chk_all("offer3", 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
    isr = 8'h00;
    tick(); chk_all("wd3", 1'b0, 3'd3, 8'h00, 1'b0, 1'b0);

    // timeout after 4 REQ cycles, re-offer, then err_clear
    isr = 8'h01;
    tick(); chk_all("to.req1", 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
    tick(); chk("to.req2", 32'(irq_valid), 32'd1);
    tick(); chk("to.req3", 32'(irq_valid), 32'd1);
    tick(); chk("to.req4", 32'(irq_valid), 32'd1);
    tick(); chk_all("to.fire", 1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    tick(); chk_all("to.reoffer", 1'b1, 3'd0, 8'h00, 1'b0, 1'b1);
    err_clear = 1'b1;
    tick(); chk_all("errclr", 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
    err_clear = 1'b0;

    // ack coincides with withdraw: ack wins
    cpu_ack = 1'b1; isr = 8'h00;
    tick(); chk_all("ackwd", 1'b0, 3'd0, 8'h01, 1'b1, 1'b0);
    // stray ack in SERVICE, new isr bit ignored
    isr = 8'h02;
    tick(); chk_all("strayack", 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    cpu_ack = 1'b0; cpu_eoi = 1'b1; dispatch_en = 1'b0;
    tick(); chk_all("eoi0", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    // stray EOI in IDLE, dispatch disabled with everything pending
    isr = 8'hFF;
    tick(); chk_all("strayeoi", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    cpu_eoi = 1'b0;
    tick(); tick();
    chk_all("dis", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    dispatch_en = 1'b1;
    tick(); chk_all("offerFF", 1'b1, EXP_FF_VEC, 8'h00, 1'b0, 1'b0);
    cpu_ack = 1'b1;
    tick(); chk_all("ackFF", 1'b0, EXP_FF_VEC, 8'h01 << EXP_FF_VEC, 1'b1, 1'b0);
    cpu_ack = 1'b0;

    // asynchronous reset in SERVICE
    #2 rst_n = 1'b0;
    #1 chk_all("midrst", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick(); chk_all("postrst", 1'b1, 3'd0, 8'h00, 1'b0, 1'b0);

    // selection order with isr held at 1000_0011
    rst_n = 1'b0; isr = 8'b1000_0011;
    tick();
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      tick();
      chk($sformatf("order%0d.valid", r), 32'(irq_valid), 32'd1);
      chk($sformatf("order%0d.vec", r), 32'(irq_vec), 32'(RR_SEQ[r]));
      cpu_ack = 1'b1;
      tick();
      chk($sformatf("order%0d.clear", r), 32'(isr_clear), 32'(8'h01 << RR_SEQ[r]));
      cpu_ack = 1'b0; cpu_eoi = 1'b1;
      tick();
      chk($sformatf("order%0d.svc", r), 32'(in_service), 32'd0);
      cpu_eoi = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_dispatcher.md
Name: irq_dispatcher

Overview:
Sequences delivery of pending interrupts from the interrupt controller's status register to a single CPU interrupt port.
- Selects one pending bit from isr and presents it as a vector with a valid/ack handshake.
- On acknowledge, issues a one-cycle isr_clear pulse for that bit.
- Tracks the in-service interrupt until end-of-interrupt (EOI).
- Sits between interrupt_controller (isr / isr_clear) and the CPU core.

Parameters:
NUM_OF_IRQS, 8, number of interrupt sources; matches interrupt_controller.
IDX_W, $clog2(NUM_OF_IRQS) (minimum 1), width of vector index.
ACK_TIMEOUT, 64, REQ cycles allowed before abandoning a request; 0 disables the timeout.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
isr  in  NUM_OF_IRQS  pending status from interrupt_controller
isr_clear  out  NUM_OF_IRQS  one-hot clear pulse to interrupt_controller
dispatch_en  in  1  global enable for starting new dispatches
irq_valid  out  1  vector offered to CPU
irq_vec  out  IDX_W  offered / in-service vector index
cpu_ack  in  1  CPU accepts offered vector
cpu_eoi  in  1  CPU finished servicing
in_service  out  1  an interrupt is being serviced
timeout_err  out  1  sticky: a request timed out
err_clear  in  1  clears timeout_err

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0; state IDLE; timeout counter 0; RR pointer 0.
- FSM states: IDLE, REQ, SERVICE. All outputs are registered.
- IDLE:
  - If dispatch_en=1 and isr != 0: register the selected index into irq_vec and go to REQ.
  - irq_valid is high starting the cycle after isr is seen nonzero (1-cycle latency).
  - Selection: lowest set index wins (fixed priority).
- REQ:
  - irq_valid=1; irq_vec is held stable.
  - The timeout counter increments each cycle in REQ.
  - cpu_ack=1: go to SERVICE. Next cycle isr_clear[irq_vec]=1 for exactly one cycle, irq_valid=0, in_service=1.
  - Else if isr[irq_vec]=0 (cleared elsewhere): withdraw and go to IDLE with irq_valid=0. No isr_clear.
  - Else if ACK_TIMEOUT!=0 and the counter reaches ACK_TIMEOUT-1: go to IDLE and set timeout_err. No isr_clear; the bit stays pending.
  - Priority when events coincide: ack > withdraw > timeout.
  - The counter clears on every REQ exit.
- SERVICE:
  - in_service=1; irq_vec holds the serviced index.
  - cpu_eoi=1: go to IDLE; in_service=0 next cycle.
  - New isr bits, including re-assertion of the same bit, are ignored until IDLE. No nesting.
- Spacing: after leaving REQ or SERVICE, the block spends at least one cycle in IDLE before the next REQ.
- Ignored inputs: cpu_ack outside REQ; cpu_eoi outside SERVICE.
- dispatch_en=0 only blocks IDLE->REQ. REQ and SERVICE complete normally.
- isr_clear is never multi-hot and is never asserted outside the cycle after an ack.
- timeout_err: set has priority over err_clear in the same cycle.
- Reset mid-operation: immediate return to reset values. isr is untouched, so pending bits are re-dispatched after reset.

Optional Feature:
Macro: IRQ_DISPATCH_RR_EN
- Defined: round-robin selection.
  - Search starts at pointer rr_ptr and wraps modulo NUM_OF_IRQS.
  - On each ack, rr_ptr <= (irq_vec+1) mod NUM_OF_IRQS; it wraps from NUM_OF_IRQS-1 to 0.
  - rr_ptr resets to 0.
- Undefined: fixed priority (lowest index wins). No pointer logic is synthesized.

Test Plan:
- isr=8'b0010_0100, dispatch_en=1 -> irq_valid next cycle, irq_vec=2. Ack -> isr_clear=8'h04 one cycle, in_service=1. EOI -> IDLE; irq_vec=5 offered after the 1-cycle IDLE gap.
- In REQ with irq_vec=3, isr[3] drops with no ack -> irq_valid=0 next cycle, isr_clear stays 0, timeout_err=0.
- ACK_TIMEOUT=4, isr=8'h01, no ack -> irq_valid high 4 cycles then low, timeout_err=1. Re-offer after the IDLE cycle. err_clear -> timeout_err=0.
- ack and isr[vec]=0 in the same cycle -> ack wins: isr_clear pulses, SERVICE entered. Stray cpu_eoi in IDLE and stray cpu_ack in SERVICE -> no state change.
- dispatch_en=0 with isr=8'hFF -> irq_valid stays 0. Deassert rst_n in SERVICE -> all outputs 0 immediately; after release, vector 0 re-offered.
- IRQ_DISPATCH_RR_EN defined, isr held at 8'b1000_0011 with ack/EOI each round and bits re-set -> vector order 0,1,7,0. Undefined -> order 0,0,0,0.
